// File: rtl/keypad_digit_history_if.sv
// Keypad digit history bundle: key sense/drive lines and control going in,
// the digit history and its strobes coming back out.
interface keypad_digit_history_if #(
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [3:0]         row;
   logic [3:0]         col;
   logic               key_press;
   logic               clear;
   logic [4*DEPTH-1:0] digits;
   logic [CW-1:0]      count;
   logic               new_digit;
   logic               err;

   modport master (
      output row, col, key_press, clear,
      input  digits, count, new_digit, err
   );

   modport slave (
      input  row, col, key_press, clear,
      output digits, count, new_digit, err
   );
endinterface

// File: rtl/keypad_digit_history.sv
// Decodes 4x4 keypad presses into hex digits and keeps a DEPTH-deep shift
// history (slot 0 newest) with a saturating count and accept/reject strobes.
module keypad_digit_history #(
   parameter int DEPTH      = 2,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   keypad_digit_history_if.slave   kp
);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {IDLE, WAIT_RELEASE} state_t;

   state_t             state_q, state_d;
   logic [4*DEPTH-1:0] digits_q, digits_d;
   logic [CW-1:0]      count_q, count_d;
   logic               new_digit_q, new_digit_d;
   logic               err_q, err_d;

   logic [3:0] r, c;
   logic [1:0] row_idx, col_idx;
   logic       row_ok, col_ok, code_ok;
   logic [3:0] key_digit;
   logic       accept;

   function automatic logic [3:0] key_map(input logic [1:0] ri, input logic [1:0] ci);
      logic [3:0] d;
      case ({ri, ci})
         4'h0: d = 4'h1;  4'h1: d = 4'h2;  4'h2: d = 4'h3;  4'h3: d = 4'hC;
         4'h4: d = 4'h4;  4'h5: d = 4'h5;  4'h6: d = 4'h6;  4'h7: d = 4'hD;
         4'h8: d = 4'h7;  4'h9: d = 4'h8;  4'hA: d = 4'h9;  4'hB: d = 4'hE;
         4'hC: d = 4'hA;  4'hD: d = 4'h0;  4'hE: d = 4'hB;  default: d = 4'hF;
      endcase
      return d;
   endfunction

   assign r = ACTIVE_LOW ? ~kp.row : kp.row;
   assign c = ACTIVE_LOW ? ~kp.col : kp.col;

   // Row bit3 is the top row; column bit0 is the left column.
   always_comb begin
      row_ok  = 1'b1;
      row_idx = 2'd0;
      case (r)
         4'b1000: row_idx = 2'd0;
         4'b0100: row_idx = 2'd1;
         4'b0010: row_idx = 2'd2;
         4'b0001: row_idx = 2'd3;
         default: row_ok  = 1'b0;
      endcase
      col_ok  = 1'b1;
      col_idx = 2'd0;
      case (c)
         4'b0001: col_idx = 2'd0;
         4'b0010: col_idx = 2'd1;
         4'b0100: col_idx = 2'd2;
         4'b1000: col_idx = 2'd3;
         default: col_ok  = 1'b0;
      endcase
   end

   assign code_ok   = row_ok & col_ok;
   assign key_digit = key_map(row_idx, col_idx);

   // Reset parks the FSM in WAIT_RELEASE so a key held through reset is ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= WAIT_RELEASE;
         digits_q    <= '0;
         count_q     <= '0;
         new_digit_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         digits_q    <= digits_d;
         count_q     <= count_d;
         new_digit_q <= new_digit_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:         if (kp.key_press)  state_d = WAIT_RELEASE;
         WAIT_RELEASE: if (!kp.key_press) state_d = IDLE;
         default:      state_d = WAIT_RELEASE;
      endcase
   end

   assign accept = (state_q == IDLE) && kp.key_press;

   // Clear overrides an accept in the same cycle; the press is still consumed.
   always_comb begin
      digits_d    = digits_q;
      count_d     = count_q;
      new_digit_d = 1'b0;
      err_d       = 1'b0;
      if (kp.clear) begin
         digits_d = '0;
         count_d  = '0;
      end else if (accept) begin
         if (code_ok) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
               digits_d[4*k +: 4] = digits_q[4*(k-1) +: 4];
            end
            digits_d[3:0] = key_digit;
            if (count_q != CW'(DEPTH)) begin
               count_d = count_q + CW'(1);
            end
            new_digit_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   assign kp.digits    = digits_q;
   assign kp.count     = count_q;
   assign kp.new_digit = new_digit_q;
   assign kp.err       = err_q;
endmodule
